// File: rtl/mem_arb_pkg.sv
// Shared types and elaboration helpers for the memory bus arbiter.
// The state encoding is common to the top and any debug tooling that decodes it.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  // A grant index needs at least one bit even for a degenerate single requester.
  function automatic int id_width(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  function automatic bit mem_lat_ok(input int mem_lat);
    return mem_lat >= 1;
  endfunction

  function automatic bit n_req_ok(input int n_req);
    return (n_req >= 2) && (n_req <= 8);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational rotating priority picker: returns the first set request bit
// found when scanning ptr, ptr+1, ... modulo N_REQ.
module rr_picker #(
  parameter int N_REQ = 3,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic             found_o,
  output logic [ID_W-1:0]  idx_o
);

  int pos;

  // Scanning from the far end backwards lets the closest hit to ptr win.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    pos     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = int'(ptr_i) + k;
      if (pos >= N_REQ) begin
        pos = pos - N_REQ;
      end
      if (req_i[pos]) begin
        found_o = 1'b1;
        idx_o   = ID_W'(pos);
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between
// N_REQ requesters; one single-word transaction in flight at a time.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            we,
  input  logic [N_REQ*ADDR_W-1:0]     addr,
  input  logic [N_REQ*DATA_W-1:0]     wdata,
  output logic [N_REQ-1:0]            ack,
  output logic [DATA_W-1:0]           rdata,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        busy,
  output logic [id_width(N_REQ)-1:0]  grant_id
);

  localparam int ID_W  = id_width(N_REQ);
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  generate
    if (!mem_lat_ok(MEM_LAT)) begin : g_lat_chk
      $error("mem_bus_arbiter: MEM_LAT must be at least 1");
    end
    if (!n_req_ok(N_REQ)) begin : g_nreq_chk
      $error("mem_bus_arbiter: N_REQ must be in 2..8");
    end
  endgenerate

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     sel_q, sel_d;
  logic                we_lat_q, we_lat_d;
  logic [ADDR_W-1:0]   addr_lat_q, addr_lat_d;
  logic [DATA_W-1:0]   wdata_lat_q, wdata_lat_d;
  logic [CNT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                pick_found;
  logic [ID_W-1:0]     pick_idx;

  rr_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      sel_q       <= '0;
      we_lat_q    <= 1'b0;
      addr_lat_q  <= '0;
      wdata_lat_q <= '0;
      lat_cnt_q   <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      we_lat_q    <= we_lat_d;
      addr_lat_q  <= addr_lat_d;
      wdata_lat_q <= wdata_lat_d;
      lat_cnt_q   <= lat_cnt_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    we_lat_d    = we_lat_q;
    addr_lat_d  = addr_lat_q;
    wdata_lat_d = wdata_lat_q;
    lat_cnt_d   = lat_cnt_q;
    rdata_d     = rdata_q;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          sel_d       = pick_idx;
          we_lat_d    = we[pick_idx];
          addr_lat_d  = addr[pick_idx*ADDR_W +: ADDR_W];
          wdata_lat_d = wdata[pick_idx*DATA_W +: DATA_W];
          if (pick_idx == ID_W'(N_REQ - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = pick_idx + 1'b1;
          end
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        if (we_lat_q) begin
          state_d = DONE;
        end else if (MEM_LAT == 1) begin
          // Single-cycle memory: the data is already valid at this edge.
          rdata_d = mem_rdata;
          state_d = DONE;
        end else begin
          lat_cnt_d = CNT_W'(MEM_LAT - 1);
          state_d   = WAIT;
        end
      end

      WAIT: begin
        lat_cnt_d = lat_cnt_q - 1'b1;
        if (lat_cnt_d == '0) begin
          rdata_d = mem_rdata;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = (state_q == ISSUE) && we_lat_q;
  assign mem_addr  = addr_lat_q;
  assign mem_wdata = wdata_lat_q;
  assign grant_id  = sel_q;
  assign rdata     = rdata_q;
  assign ack       = (state_q == DONE) ? ({{(N_REQ-1){1'b0}}, 1'b1} << sel_q) : '0;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one single-port synchronous memory between N requesters (CPU fetch, CPU load/store, I/O DMA).
- Accepts one single-word transaction at a time, drives the memory port, waits the fixed read latency, and returns data with a one-cycle ack.
- Sits between the requesters and the block-RAM wrapper.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- ADDR_W, 16, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from mem_en to valid mem_rdata (>=1; 0 is illegal, elaboration assertion).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  N_REQ  per-requester request, held until ack.
- we  in  N_REQ  per-requester write enable, valid with req.
- addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W].
- wdata  in  N_REQ*DATA_W  packed write data, same packing.
- ack  out  N_REQ  one-hot, one-cycle completion pulse.
- rdata  out  DATA_W  registered read data, valid while ack of a read is high.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.
- busy  out  1  high in every state except IDLE.
- grant_id  out  $clog2(N_REQ)  index of the requester currently being served.

Behaviour:
- Reset (sync, active-high): state=IDLE; ptr=0; ack=0; rdata=0; mem_en=0; mem_we=0; mem_addr=0; mem_wdata=0; grant_id=0; busy=0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req bit is set, pick the first set bit searching ptr, ptr+1, … mod N_REQ.
  - Register sel=grant_id and latch addr/we/wdata of sel.
  - Set ptr=(sel+1) mod N_REQ.
  - Go to ISSUE. Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_en=1; mem_we=we_latched; mem_addr and mem_wdata from the latch.
  - On a write, go to DONE.
  - On a read, load lat_cnt=MEM_LAT-1 and go to WAIT; if MEM_LAT==1, go directly to DONE and capture rdata at that edge.
- WAIT:
  - mem_en=0. Decrement lat_cnt.
  - When lat_cnt==0, capture mem_rdata into rdata and go to DONE.
- DONE (1 cycle): ack[sel]=1, all other ack bits 0; then go to IDLE.
- Latency, with the request first seen in IDLE at cycle T:
  - mem_en in cycle T+1.
  - Write ack in cycle T+2.
  - Read ack in cycle T+1+MEM_LAT, rdata = mem_rdata sampled in cycle T+MEM_LAT.
  - Minimum spacing between grants: 3 cycles (write) or 2+MEM_LAT cycles (read).
- Handshake rules:
  - The requester holds req, we, addr and wdata stable until ack, and deasserts req in the cycle after ack.
  - Since DONE always returns to IDLE, a req still high in IDLE starts a new transaction.
- Boundary conditions:
  - req dropped mid-transaction: transaction still completes and ack still pulses.
  - req of non-selected requesters during a transaction: ignored until IDLE.
  - Simultaneous requests: round-robin from ptr. With all requesters continuously requesting, grant order is 0,1,2,0,…
  - Single requester repeating: served every transaction; ptr wraps with no starvation.
  - ptr wrap-around: (N_REQ-1)+1 → 0.
  - rst mid-transaction: state=IDLE next cycle, mem_en=0, no ack issued, in-flight read data discarded, ptr=0.
  - rdata holds its last captured value outside ack.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, ISSUE, WAIT, DONE), the MEM_LAT>=1 check helper, and the localparam function for id width.
- Sub-module rr_picker (combinational): inputs req and ptr; outputs found and idx, the first set bit at or after ptr, rotating.

Test Plan:
- Reset, then req[0] with we=0, addr=16'h0010, memory model returning 32'hDEAD_BEEF at MEM_LAT=2 → mem_en at T+1 with mem_addr=16'h0010; ack[0] at T+3; rdata=32'hDEADBEEF.
- req[1] write, addr=16'h0020, wdata=32'h1234_5678 → mem_en=mem_we=1 at T+1 with those values; ack[1] at T+2; readback by req[2] returns 32'h12345678.
- req=3'b111 held, each requester deasserting after its ack and reasserting → grant_id sequence 0,1,2,0,1,2; no ack overlap; busy low for exactly one cycle between transactions.
- ptr=2 (after serving 1), then req=3'b011 → requester 0 granted first (wrap), then 1.
- rst asserted in WAIT during a read → next cycle state IDLE, mem_en=0, no ack pulse, grant_id=0; a following req[2] is served normally.
- MEM_LAT=1 build, read of addr 16'h0001 → ack at T+2 with correct rdata; WAIT never entered.
